// File: rtl/tone_seq_pkg.sv
// Shared types and widths for the tone sequencer.
// The GAP state is only reachable in builds with TONE_SEQ_GAP_EN defined.
package tone_seq_pkg;

   localparam int FREQ_W    = 8;
   localparam int DUR_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [FREQ_W-1:0]    freq;
      logic [DUR_W_DEF-1:0] dur;
   } tone_entry_t;

endpackage

// File: rtl/tone_seq_table.sv
// Step table: DEPTH x {freq, dur} registers, synchronous write, combinational read.
// Contents are deliberately left unreset.
module tone_seq_table
   import tone_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DUR_W = DUR_W_DEF
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [FREQ_W-1:0]        wr_freq,
   input  logic [DUR_W-1:0]         wr_dur,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [FREQ_W-1:0]        rd_freq,
   output logic [DUR_W-1:0]         rd_dur
);

   // Local entry type so the duration field follows this instance's DUR_W.
   typedef struct packed {
      logic [FREQ_W-1:0] freq;
      logic [DUR_W-1:0]  dur;
   } entry_t;

   entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= '{freq: wr_freq, dur: wr_dur};
   end

   assign rd_freq = mem[rd_addr].freq;
   assign rd_dur  = mem[rd_addr].dur;

endmodule

// File: rtl/tone_sequencer.sv
// Walks a (freq, duration) table and drives the square-wave generator's divisor.
// Define TONE_SEQ_GAP_EN to insert GAP_CYCLES silent cycles between steps.
module tone_sequencer
   import tone_seq_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int DUR_W      = DUR_W_DEF,
   parameter int GAP_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [FREQ_W-1:0]        wr_freq,
   input  logic [DUR_W-1:0]         wr_dur,
   input  logic [$clog2(DEPTH)-1:0] last_idx,
   input  logic                     loop,
   input  logic                     start,
   input  logic                     stop,
   output logic [FREQ_W-1:0]        freq,
   output logic [$clog2(DEPTH)-1:0] step_idx,
   output logic                     busy,
   output logic                     done
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || GAP_CYCLES < 1) begin : g_bad_param
   end

   state_t            state;
   logic [AW-1:0]     last_q;
   logic [AW-1:0]     nxt_idx;
   logic [AW-1:0]     rd_addr;
   logic [DUR_W-1:0]  cnt;
   logic [DUR_W-1:0]  rd_dur;
   logic [FREQ_W-1:0] rd_freq;
   logic              tbl_we;

`ifdef TONE_SEQ_GAP_EN
   localparam int GW = $clog2(GAP_CYCLES + 1);
   logic [GW-1:0] gcnt;
`endif

   assign tbl_we  = wr_en && (state == IDLE);
   assign nxt_idx = (step_idx == last_q) ? '0 : step_idx + 1'b1;

   // The read port looks ahead to whichever entry the next load will need.
   always_comb begin
      rd_addr = nxt_idx;
      if (state == IDLE)     rd_addr = '0;
      else if (state == GAP) rd_addr = step_idx;
   end

   tone_seq_table #(.DEPTH(DEPTH), .DUR_W(DUR_W)) u_table (
      .clk     (clk),
      .wr_en   (tbl_we),
      .wr_addr (wr_addr),
      .wr_freq (wr_freq),
      .wr_dur  (wr_dur),
      .rd_addr (rd_addr),
      .rd_freq (rd_freq),
      .rd_dur  (rd_dur)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         freq     <= '0;
         step_idx <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         last_q   <= '0;
`ifdef TONE_SEQ_GAP_EN
         gcnt     <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state    <= PLAY;
                  busy     <= 1'b1;
                  last_q   <= last_idx;
                  step_idx <= '0;
                  freq     <= rd_freq;
                  cnt      <= rd_dur;
               end
            end
            PLAY: begin
               if (stop) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  freq     <= '0;
                  step_idx <= '0;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (step_idx != last_q || loop) begin
                  step_idx <= nxt_idx;
`ifdef TONE_SEQ_GAP_EN
                  state    <= GAP;
                  freq     <= '0;
                  gcnt     <= GW'(GAP_CYCLES - 1);
`else
                  freq     <= rd_freq;
                  cnt      <= rd_dur;
`endif
               end else begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  freq     <= '0;
                  step_idx <= '0;
                  done     <= 1'b1;
               end
            end
`ifdef TONE_SEQ_GAP_EN
            GAP: begin
               if (stop) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  freq     <= '0;
                  step_idx <= '0;
               end else if (gcnt != '0) begin
                  gcnt <= gcnt - 1'b1;
               end else begin
                  state <= PLAY;
                  freq  <= rd_freq;
                  cnt   <= rd_dur;
               end
            end
`endif
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               freq     <= '0;
               step_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboarded bench for tone_sequencer: a step-level model queues per-cycle
// expectations and a negedge monitor compares them against the outputs.
module tb_tone_sequencer;

   localparam int DEPTH      = 16;
   localparam int DUR_W      = 8;
   localparam int GAP_CYCLES = 2;
   localparam int AW         = $clog2(DEPTH);
`ifdef TONE_SEQ_GAP_EN
   localparam int MGAP = GAP_CYCLES;
`else
   localparam int MGAP = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, wr_en, loop, start, stop;
   logic [AW-1:0]    wr_addr, last_idx;
   logic [7:0]       wr_freq;
   logic [DUR_W-1:0] wr_dur;
   logic [7:0]       freq;
   logic [AW-1:0]    step_idx;
   logic             busy, done;

   tone_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq),
      .wr_dur(wr_dur), .last_idx(last_idx), .loop(loop), .start(start), .stop(stop),
      .freq(freq), .step_idx(step_idx), .busy(busy), .done(done)
   );

   typedef struct {
      int freq;
      int step;
      int busy;
      int done;
   } exp_t;

   exp_t exp_q[$];
   int total = 0;
   int bad   = 0;

   // Reference model: playback described as "current step, cycles left in it,
   // silent gap cycles left", advanced once per clock edge.
   int tf[DEPTH];
   int td[DEPTH];
   int m_busy = 0, m_step = 0, m_rem = 0, m_gap = 0, m_last = 0, m_fcur = 0, m_done = 0;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, req);
      end
   endtask

   task automatic enter_step(input int idx);
      m_step = idx;
      m_rem  = td[idx] + 1;
      m_fcur = tf[idx];
   endtask

   task automatic tick();
      exp_t e;
      if (rst) begin
         m_busy = 0; m_step = 0; m_gap = 0; m_done = 0;
         if (wr_en) begin tf[wr_addr] = wr_freq; td[wr_addr] = wr_dur; end
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (start && !stop) begin
               m_busy = 1; m_gap = 0; m_last = last_idx;
               enter_step(0);
            end
            if (wr_en) begin tf[wr_addr] = wr_freq; td[wr_addr] = wr_dur; end
         end else if (stop) begin
            m_busy = 0; m_step = 0; m_gap = 0;
         end else if (m_gap > 0) begin
            m_gap--;
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               if (m_step != m_last || loop) begin
                  enter_step((m_step == m_last) ? 0 : (m_step + 1) % DEPTH);
                  m_gap = MGAP;
               end else begin
                  m_busy = 0; m_step = 0; m_done = 1;
               end
            end
         end
      end
      e.freq = (m_busy != 0 && m_gap == 0) ? m_fcur : 0;
      e.step = m_step;
      e.busy = m_busy;
      e.done = m_done;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("freq", int'(freq), e.freq);
         chk("step_idx", int'(step_idx), e.step);
         chk("busy", int'(busy), e.busy);
         chk("done", int'(done), e.done);
      end
   end

   task automatic wr(input int a, input int f, input int d);
      wr_en = 1'b1; wr_addr = AW'(a); wr_freq = 8'(f); wr_dur = DUR_W'(d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; stop = 1'b0; loop = 1'b0; wr_en = 1'b0;
      wr_addr = '0; wr_freq = '0; wr_dur = '0; last_idx = 2;

      // Table loaded while reset is held with start high; outputs stay silent.
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 0)      wr(0, 10, 2);
         else if (i == 1) wr(1, 20, 0);
         else if (i == 2) wr(2, 30, 1);
         else             wr(i, int'($urandom_range(255)), int'($urandom_range(3)));
      end
      tick();
      rst = 1'b0;
      tick();
      start = 1'b0;
      repeat (9) tick();

      // Looping, then drop loop while step 1 plays.
      loop = 1'b1;
      pulse_start();
      repeat (14) tick();
      for (int k = 0; k < 20 && m_step != 1; k++) tick();
      loop = 1'b0;
      repeat (10) tick();

      // Asynchronous reset mid-playback, checked before any clock edge.
      loop = 1'b1;
      pulse_start();
      repeat (4) tick();
      #6;
      rst = 1'b1;
      #1;
      chk("async_rst_freq", int'(freq), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_step", int'(step_idx), 0);
      tick();
      rst = 1'b0;
      loop = 1'b0;
      tick();

      // Stop during step 1, then start and stop together from IDLE.
      pulse_start();
      for (int k = 0; k < 20 && m_step != 1; k++) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      repeat (3) tick();
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      repeat (3) tick();

      // A write while busy is dropped; the same write from IDLE sticks.
      pulse_start();
      wr(0, 99, 1);
      repeat (10) tick();
      wr(0, 99, 1);
      pulse_start();
      repeat (10) tick();

`ifdef TONE_SEQ_GAP_EN
      wr(0, 5, 0);
      wr(1, 6, 0);
      last_idx = 1; loop = 1'b1;
      pulse_start();
      repeat (12) tick();
      stop = 1'b1; tick(); stop = 1'b0; loop = 1'b0;
      tick();
`endif

      for (int n = 0; n < 3000; n++) begin
         wr_en    = ($urandom_range(3) == 0);
         wr_addr  = AW'($urandom_range(DEPTH - 1));
         wr_freq  = ($urandom_range(5) == 0) ? 8'd0 : 8'($urandom_range(255));
         wr_dur   = DUR_W'($urandom_range(3));
         start    = ($urandom_range(7) == 0);
         stop     = ($urandom_range(39) == 0);
         last_idx = AW'($urandom_range(DEPTH - 1));
         if ($urandom_range(15) == 0) loop = ~loop;
         tick();
      end
      wr_en = 1'b0; start = 1'b0; stop = 1'b0;

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Upstream stage for the square-wave generator: plays a programmable sequence of tones by driving the generator's 8-bit `freq` input. It holds a small table of (freq, duration) steps, starts on a pulse, and walks the table one step at a time, holding each `freq` for its programmed number of cycles. It optionally loops and returns `freq` = 0 (generator disabled) when idle.

## Interface
- `DEPTH`, 16: table entries; power of two, ≥ 2.
- `DUR_W`, 8: duration field width.
- `GAP_CYCLES`, 2: silent cycles between steps, ≥ 1. Used only when `TONE_SEQ_GAP_EN` is defined.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: table write strobe.
- `wr_addr` in $clog2(DEPTH): table write address.
- `wr_freq` in 8: frequency divisor for the entry.
- `wr_dur` in DUR_W: duration field for the entry.
- `last_idx` in $clog2(DEPTH): index of the final step; latched on start.
- `loop` in 1: level; when high, wrap from `last_idx` to step 0.
- `start` in 1: pulse; begin playback from step 0.
- `stop` in 1: pulse; abort playback.
- `freq` out 8: registered divisor to the generator; 0 when silent.
- `step_idx` out $clog2(DEPTH): step currently playing.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at natural completion.

## Operation
- States:
  - IDLE
  - PLAY
  - GAP (exists only with `TONE_SEQ_GAP_EN`)
- Table writes:
  - Accepted only in IDLE; `wr_en` while `busy` is ignored.
  - Table contents are not reset.
- IDLE:
  - `start` → PLAY; latch `last_idx`; `step_idx` = 0; `freq` = table[0].freq; duration counter = table[0].dur.
  - `start` while busy is ignored.
- PLAY:
  - Each step lasts dur+1 cycles (dur = 0 gives 1 cycle).
  - The counter decrements each cycle. At 0:
    - If `step_idx` ≠ latched last: advance to step+1.
    - If at last and `loop` = 1: wrap to 0.
    - If at last and `loop` = 0: go to IDLE, `freq` = 0, pulse `done`.
  - `loop` is sampled at the final step's expiry only.
- `stop` in PLAY or GAP:
  - → IDLE at the next edge, `freq` = 0, `step_idx` = 0.
  - No `done` pulse.
  - `stop` and `start` in the same cycle: `stop` wins.
- A step with freq = 0 is a rest: it is played normally and held for its duration.
- `step_idx` arithmetic is modulo DEPTH. The wrap is explicit on `last_idx`, never by overflow.

## Timing
- Reset values: `freq` = 0, `step_idx` = 0, `busy` = 0, `done` = 0, state IDLE.
- Reset mid-playback returns to IDLE immediately (asynchronous).
- `start` sampled at edge N: `freq` = table[0].freq and `busy` = 1 from edge N.
- Step transition: the new `freq` appears on the edge after the counter reaches 0. There are no bubble cycles (without gap).
- `done` is high for exactly the cycle following the last step's final cycle, coincident with `busy` = 0.
- A write to an entry takes effect for any `start` sampled on a later edge.

## Configuration
- `TONE_SEQ_GAP_EN` defined:
  - Between consecutive steps, including the loop wrap, enter GAP for `GAP_CYCLES` cycles.
  - During GAP, `freq` = 0 and `step_idx` already holds the next index.
  - No gap after the final non-looping step.
- Not defined: GAP state and its counter are absent; steps run back-to-back.

## Structure
- Package `tone_seq_pkg`:
  - State enum typedef (IDLE/PLAY/GAP).
  - `FREQ_W` = 8.
  - Default `DUR_W`.
  - Table entry struct {freq, dur}.
- Sub-module `tone_seq_table`: DEPTH×entry register array; synchronous write port, combinational read port.

## Test plan
- Reset with `start` held high → `freq` = 0, `busy` = 0 until `rst` falls; playback starts on the first edge with `start` sampled.
- Table {(10,2),(20,0),(30,1)}, `last_idx` = 2, `loop` = 0, `start` → `freq` is 10 for 3 cycles, 20 for 1, 30 for 2; then 0 with `done` high for 1 cycle.
- Same table with `loop` = 1 → sequence 10,10,10,20,30,30,10… repeats; deassert `loop` during step 1 → ends after step 2 with `done`.
- `stop` during step 1 → `freq` = 0, `busy` = 0 next edge, no `done`; `start` + `stop` in the same cycle from IDLE → stays IDLE.
- `wr_en` to entry 0 while busy → ignored; after completion the write succeeds and the next playback uses the new value.
- With `TONE_SEQ_GAP_EN`, `GAP_CYCLES` = 2, table {(5,0),(6,0)}, `loop` = 1 → `freq` is 5,0,0,6,0,0,5…
